// File: rtl/adder_result_accumulator.sv
// adder_result_accumulator
//   Accumulates N_SAMPLES 5-bit adder results ({cout_in, sum_in}) into one
//   frame sum. A frame is opened by a start pulse in IDLE. The block holds
//   the result in DONE until the consumer takes it.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   start            one-cycle pulse that opens a frame; only honoured in IDLE
//   in_valid/in_ready   upstream handshake; in_ready is high only in ACCUM
//   sum_in, cout_in  adder result; the operand is {cout_in, sum_in}
//   out_valid/out_ready downstream handshake; out_valid is high only in DONE
//   acc_out          running or final sum, modulo 2^ACC_W
//   count_out        number of results accepted in the current frame
//   overflow         sticky flag; set on any accumulator carry-out in the frame
//   busy             high in ACCUM and DONE
module adder_result_accumulator #(
  parameter int N_SAMPLES = 8,
  parameter int ACC_W     = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       sum_in,
  input  logic             cout_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [7:0]       count_out,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0] N_LAST = 8'(N_SAMPLES);

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [7:0]       cnt, cnt_nx;
  logic             ovf, ovf_nx;

  // One spare bit on top of the accumulator catches the carry-out.
  logic [ACC_W:0]   operand;
  logic [ACC_W:0]   sum_ext;

  assign operand = {{(ACC_W-4){1'b0}}, cout_in, sum_in};
  assign sum_ext = {1'b0, acc} + operand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      ovf   <= ovf_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    ovf_nx   = ovf;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = ACCUM;
          acc_nx   = '0;
          cnt_nx   = '0;
          ovf_nx   = 1'b0;
        end
      end
      ACCUM: begin
        // in_ready is implied by the state, so in_valid alone marks a transfer.
        if (in_valid) begin
          acc_nx = sum_ext[ACC_W-1:0];
          cnt_nx = cnt + 8'd1;
          if (sum_ext[ACC_W]) ovf_nx = 1'b1;
          if (cnt + 8'd1 == N_LAST) state_nx = DONE;
        end
      end
      DONE: begin
        // Result registers are left untouched on exit; they stay readable
        // until the next start clears them.
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decode the state register only; no input feeds through.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign acc_out   = acc;
  assign count_out = cnt;
  assign overflow  = ovf;

endmodule

// File: tb/tb_adder_result_accumulator.sv
module tb_adder_result_accumulator;
  localparam int N = 8;
  localparam int W = 12;

  typedef struct packed {
    logic [W-1:0] acc;
    logic [7:0]   cnt;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // default-parameter instance
  logic         start = 0, in_valid = 0, out_ready = 0, cout_in = 0;
  logic [3:0]   sum_in = 0;
  logic         in_ready, out_valid, overflow, busy;
  logic [W-1:0] acc_out;
  logic [7:0]   count_out;

  // narrow instance for the wrap/overflow case
  logic         start2 = 0, in_valid2 = 0, out_ready2 = 0, cout2 = 0;
  logic [3:0]   sum2 = 0;
  logic         in_ready2, out_valid2, overflow2, busy2;
  logic [5:0]   acc2;
  logic [7:0]   count2;

  adder_result_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .sum_in(sum_in), .cout_in(cout_in), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .count_out(count_out), .overflow(overflow), .busy(busy));

  adder_result_accumulator #(.N_SAMPLES(3), .ACC_W(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
    .sum_in(sum2), .cout_in(cout2), .out_valid(out_valid2), .out_ready(out_ready2),
    .acc_out(acc2), .count_out(count2), .overflow(overflow2), .busy(busy2));

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every DONE cycle must show the result at the head of the
  // scoreboard; the entry retires on the out_valid/out_ready handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual_acc=%0d expected=none", acc_out);
      end else begin
        chk("res_acc", 64'(acc_out), 64'(sbq[0].acc));
        chk("res_cnt", 64'(count_out), 64'(sbq[0].cnt));
        chk("res_ovf", 64'(overflow), 64'(sbq[0].ovf));
        if (out_ready) void'(sbq.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_in_ready"}, 64'(in_ready), 0);
    chk({nm, "_out_valid"}, 64'(out_valid), 0);
    chk({nm, "_acc"}, 64'(acc_out), 0);
    chk({nm, "_cnt"}, 64'(count_out), 0);
    chk({nm, "_ovf"}, 64'(overflow), 0);
    chk({nm, "_busy"}, 64'(busy), 0);
  endtask

  // One full frame on the default instance. The reference is plain
  // arithmetic: running sum of operands, wrapped to W bits for acc_out, with
  // overflow meaning the true total reached 2^W.
  task automatic do_frame(input logic [4:0] ops[N], input bit gaps, input bit mid_start,
                          input int hold, input bit start_on_exit);
    int   total;
    exp_t e;
    total = 0;
    for (int i = 0; i < N; i++) total += int'(ops[i]);
    e.acc = W'(total % (1 << W));
    e.cnt = 8'(N);
    e.ovf = (total >= (1 << W));
    sbq.push_back(e);

    start = 1; step(); start = 0;
    chk("open_in_ready", 64'(in_ready), 1);
    chk("open_busy", 64'(busy), 1);
    chk("open_acc", 64'(acc_out), 0);
    chk("open_cnt", 64'(count_out), 0);

    total = 0;
    for (int i = 0; i < N; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 0;
        repeat ($urandom_range(1, 2)) step();
        chk("gap_acc", 64'(acc_out), 64'(total % (1 << W)));
        chk("gap_cnt", 64'(count_out), 64'(i));
      end
      if (mid_start && i == 2) begin
        start = 1; in_valid = 0; step(); start = 0;
        chk("midstart_acc", 64'(acc_out), 64'(total % (1 << W)));
        chk("midstart_cnt", 64'(count_out), 2);
      end
      in_valid = 1;
      {cout_in, sum_in} = ops[i];
      step();
      in_valid = 0;
      total += int'(ops[i]);
      chk("run_acc", 64'(acc_out), 64'(total % (1 << W)));
      chk("run_cnt", 64'(count_out), 64'(i + 1));
    end
    chk("done_out_valid", 64'(out_valid), 1);
    chk("done_in_ready", 64'(in_ready), 0);

    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_acc", 64'(acc_out), 64'(e.acc));
      chk("hold_out_valid", 64'(out_valid), 1);
    end
    out_ready = 1;
    start = start_on_exit;
    step();
    out_ready = 0;
    start = 0;
    chk("exit_out_valid", 64'(out_valid), 0);
    chk("exit_busy", 64'(busy), 0);
    chk("exit_in_ready", 64'(in_ready), 0);
    chk("exit_acc_kept", 64'(acc_out), 64'(e.acc));
    step();
    chk("idle_busy", 64'(busy), 0);
    chk("idle_cnt_kept", 64'(count_out), 8);
  endtask

  initial begin
    logic [4:0] ops[N];
    logic [5:0] exp6[3];

    // reset asserted between edges: outputs must clear without a clock edge
    #2 rst_n = 0;
    #1 chk_all_zero("reset");
    #24 rst_n = 1;
    step();
    chk("post_reset_busy", 64'(busy), 0);

    // eight back-to-back 3s, 5-cycle hold, start coinciding with the exit
    for (int i = 0; i < N; i++) ops[i] = 5'd3;
    do_frame(ops, 0, 0, 5, 1);

    // randomized frames, some with gaps, one with a start pulse mid-frame
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) ops[i] = 5'($urandom_range(0, 31));
      do_frame(ops, f % 2 == 1, f == 3, int'($urandom_range(0, 4)), f == 2);
    end

    // abort mid-frame with an asynchronous reset after the 4th transfer
    start = 1; step(); start = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; {cout_in, sum_in} = 5'd17; step(); in_valid = 0;
    end
    chk("abort_pre_cnt", 64'(count_out), 4);
    #3 rst_n = 0;
    #1 chk_all_zero("abort");
    step(); step();
    #3 rst_n = 1;
    step();
    chk("abort_idle_out_valid", 64'(out_valid), 0);
    for (int i = 0; i < N; i++) ops[i] = 5'd1;
    do_frame(ops, 0, 0, 1, 0);

    // narrow accumulator: 31, 62, then wrap to 29 with overflow
    exp6[0] = 6'd31; exp6[1] = 6'd62; exp6[2] = 6'd29;
    start2 = 1; step(); start2 = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid2 = 1; {cout2, sum2} = 5'd31; step(); in_valid2 = 0;
      chk("w6_acc", 64'(acc2), 64'(exp6[i]));
      chk("w6_cnt", 64'(count2), 64'(i + 1));
      chk("w6_ovf", 64'(overflow2), (i == 2) ? 64'd1 : 64'd0);
    end
    chk("w6_out_valid", 64'(out_valid2), 1);
    step(); step();
    chk("w6_hold_ovf", 64'(overflow2), 1);
    chk("w6_hold_acc", 64'(acc2), 29);
    out_ready2 = 1; step(); out_ready2 = 0;
    chk("w6_exit_out_valid", 64'(out_valid2), 0);
    chk("w6_exit_ovf_kept", 64'(overflow2), 1);
    start2 = 1; step(); start2 = 0;
    chk("w6_restart_ovf", 64'(overflow2), 0);
    chk("w6_restart_acc", 64'(acc2), 0);

    step();
    chk("sb_drained", 64'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
